// File: rtl/axi_wr_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_wr_slave_mem
//
// AXI3 write-path slave responder. Accepts one write burst at a time on the
// AW/W channels, stores the beats in an internal word-addressed memory and
// returns a single B response per burst. A combinational debug port exposes
// any memory word without going through AXI.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   AWID..AWVALID       write address channel inputs, AWREADY output
//   WID..WVALID         write data channel inputs, WREADY output
//   BID, BRESP, BVALID  write response outputs, BREADY input
//   dbg_addr            debug word index
//   dbg_rdata           mem[dbg_addr], combinational
//
// Burst handling
//   IDLE  : AWREADY high; an AW handshake captures the burst and moves to DATA.
//   DATA  : WREADY high with no wait states; the burst ends on beat LEN+1
//           regardless of WLAST.
//   RESP  : BVALID high with BID/BRESP held until BREADY; then back to IDLE,
//           where AWREADY returns one cycle later.
//   Any protocol or addressing problem seen during the burst is collected
//   in a sticky error flag and reported as SLVERR.
// ---------------------------------------------------------------------------
module axi_wr_slave_mem #(
    parameter int A_WIDTH   = 16,
    parameter int D_WIDTH   = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    // write address channel
    input  logic [8:0]                   AWID,
    input  logic [A_WIDTH-1:0]           AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    // write data channel
    input  logic [8:0]                   WID,
    input  logic [D_WIDTH-1:0]           WDATA,
    input  logic [D_WIDTH/8-1:0]         WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    // write response channel
    output logic [8:0]                   BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    // debug read port
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [D_WIDTH-1:0]           dbg_rdata
);

    localparam int STRB_W = D_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);     // byte-offset bits inside a word
    localparam int IDX_W  = $clog2(MEM_DEPTH);  // word-index bits

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and registered handshake outputs
    // -----------------------------------------------------------------------
    state_t state_q, state_d;
    logic   awready_q, awready_d;
    logic   wready_q,  wready_d;
    logic   bvalid_q,  bvalid_d;

    // captured burst attributes and per-burst progress
    logic [8:0]         id_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [3:0]         len_q;
    logic [2:0]         size_q;
    logic [1:0]         burst_q;
    logic [3:0]         beat_cnt_q;
    logic               err_q;       // sticky SLVERR for the current burst
    logic               nowrite_q;   // burst rejected at AW time: drop every beat
    logic [8:0]         bid_q;
    logic [1:0]         bresp_q;

    logic [D_WIDTH-1:0] mem [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic aw_hs, w_hs, b_hs, last_beat;

    assign aw_hs     = AWVALID && awready_q;
    assign w_hs      = WVALID  && wready_q;
    assign b_hs      = bvalid_q && BREADY;
    assign last_beat = (beat_cnt_q == len_q);

    // -----------------------------------------------------------------------
    // AW-time checks: these make the whole burst unwritable
    // -----------------------------------------------------------------------
    logic [A_WIDTH-1:0] aw_bytes;
    logic               wrap_len_ok;
    logic               aw_err;

    assign aw_bytes    = A_WIDTH'(1) << AWSIZE;
    assign wrap_len_ok = (AWLEN == 4'd1) || (AWLEN == 4'd3) ||
                         (AWLEN == 4'd7) || (AWLEN == 4'd15);
    assign aw_err      = (AWSIZE > 3'(LANE_W))
                      || (AWBURST == BURST_RSVD)
                      || ((AWBURST == BURST_WRAP) && !wrap_len_ok)
                      || ((AWBURST == BURST_WRAP) && (|(AWADDR & (aw_bytes - A_WIDTH'(1)))));

    // -----------------------------------------------------------------------
    // Per-beat address decode and checks
    // -----------------------------------------------------------------------
    logic [A_WIDTH-1:0] word_full;
    logic [IDX_W-1:0]   word_idx;
    logic               out_of_range;
    logic               beat_err;
    logic               beat_write;

    assign word_full    = addr_q >> LANE_W;
    assign word_idx     = word_full[IDX_W-1:0];
    // any bit above the index range means the word lies past the memory
    assign out_of_range = |(word_full >> IDX_W);
    assign beat_err     = out_of_range || (WID != id_q) || (WLAST != last_beat);
    assign beat_write   = w_hs && !nowrite_q && !out_of_range;

    // -----------------------------------------------------------------------
    // Next beat address (modulo 2^A_WIDTH by construction)
    // -----------------------------------------------------------------------
    logic [A_WIDTH-1:0] bytes_q;
    logic [A_WIDTH-1:0] bound_q;
    logic [A_WIDTH-1:0] addr_next;

    assign bytes_q = A_WIDTH'(1) << size_q;
    assign bound_q = (A_WIDTH'(len_q) + A_WIDTH'(1)) << size_q;

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            // align down first so an unaligned start lands on the next slot
            BURST_INCR: addr_next = (addr_q & ~(bytes_q - A_WIDTH'(1))) + bytes_q;
            BURST_WRAP: addr_next = (addr_q & ~(bound_q - A_WIDTH'(1)))
                                  | ((addr_q + bytes_q) & (bound_q - A_WIDTH'(1)));
            default:    addr_next = addr_q;   // FIXED and reserved hold the address
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: next state and next handshake outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // AWREADY rises one cycle after entering IDLE and drops on the handshake
                awready_d = !aw_hs;
                if (aw_hs) begin
                    state_d  = DATA;
                    wready_d = 1'b1;
                end
            end
            DATA: begin
                wready_d = 1'b1;
                if (w_hs && last_beat) begin
                    wready_d = 1'b0;
                    bvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                bvalid_d = 1'b1;
                if (b_hs) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Burst capture, progress, error flag and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            nowrite_q  <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                id_q       <= AWID;
                addr_q     <= AWADDR;
                len_q      <= AWLEN;
                size_q     <= AWSIZE;
                burst_q    <= AWBURST;
                beat_cnt_q <= '0;
                err_q      <= aw_err;
                nowrite_q  <= aw_err;
            end
            if (w_hs) begin
                addr_q     <= addr_next;
                beat_cnt_q <= beat_cnt_q + 4'd1;
                err_q      <= err_q || beat_err;
                if (last_beat) begin
                    // loaded once per burst, so BID/BRESP stay stable through backpressure
                    bid_q   <= id_q;
                    bresp_q <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory
    // -----------------------------------------------------------------------
    // NOTE: the array has a synchronous clear, which keeps it in flops rather
    // than a RAM macro; that is intended so reset leaves every word at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (beat_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem[word_idx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_slave_mem
//
// Directed and randomized write bursts into axi_wr_slave_mem. Expected memory
// contents and responses come from a behavioural model that walks the beat
// addresses arithmetically and applies byte strobes into a plain array.
// ---------------------------------------------------------------------------
module tb_axi_wr_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  AWID;
    logic [15:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [8:0]  WID;
    logic [15:0] WDATA;
    logic [1:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [8:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_rdata;

    axi_wr_slave_mem #(
        .A_WIDTH  (16),
        .D_WIDTH  (16),
        .MEM_DEPTH(256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WID      (WID),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] ref_mem   [256];
    logic [15:0] beat_data [16];
    logic [1:0]  beat_strb [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input int idx, input string tag, input logic [15:0] exp);
        dbg_addr = 8'(idx);
        #1;
        check(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic scan_mem(input string tag);
        for (int i = 0; i < 256; i++) begin
            dbg_addr = 8'(i);
            #1;
            check($sformatf("%s_mem[%0d]", tag, i), 32'(dbg_rdata), 32'(ref_mem[i]));
        end
    endtask

    // Reference model: walk the byte addresses of the burst, update the
    // expected memory and work out whether the response must be SLVERR.
    task automatic model_burst(input int addr, input int len, input int size, input int burst,
                               input int wid_bad, input logic [15:0] wlast_flip,
                               output bit err);
        int a, bytes, bound, idx;
        bit nowrite;
        bytes   = 1 << size;
        a       = addr;
        nowrite = (size > 1) || (burst == 3)
               || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
               || (burst == 2 && (addr % bytes) != 0);
        err = nowrite;
        for (int k = 0; k <= len; k++) begin
            idx = a / 2;
            if (idx >= 256) begin
                err = 1'b1;
            end else if (!nowrite) begin
                if (beat_strb[k][0]) ref_mem[idx][7:0]  = beat_data[k][7:0];
                if (beat_strb[k][1]) ref_mem[idx][15:8] = beat_data[k][15:8];
            end
            if (k == wid_bad)  err = 1'b1;
            if (wlast_flip[k]) err = 1'b1;
            case (burst)
                1: a = ((a / bytes) * bytes + bytes) % 65536;
                2: begin
                    bound = (len + 1) * bytes;
                    a = (a / bound) * bound + (a + bytes) % bound;
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_burst(input logic [8:0] id, input logic [15:0] addr, input int len,
                            input int size, input int burst, input int wid_bad,
                            input logic [15:0] wlast_flip, input int bdelay,
                            input bit early_w, input bit gaps);
        bit          exp_err;
        int          cnt;
        logic [1:0]  exp_resp;
        model_burst(int'(addr), len, size, burst, wid_bad, wlast_flip, exp_err);
        exp_resp = exp_err ? 2'b10 : 2'b00;

        AWID    = id;
        AWADDR  = addr;
        AWLEN   = 4'(len);
        AWSIZE  = 3'(size);
        AWBURST = 2'(burst);
        AWVALID = 1'b1;
        if (early_w) begin
            WVALID = 1'b1;
            WDATA  = beat_data[0];
            WSTRB  = beat_strb[0];
            WID    = id;
            WLAST  = (len == 0) ^ wlast_flip[0];
        end
        cnt = 0;
        while (!AWREADY && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!AWREADY) begin
            check("aw_timeout", 32'(AWREADY), 32'd1);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            return;
        end
        if (early_w) check("w_blocked_during_aw", 32'(WREADY), 32'd0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        check("awready_low_in_data", 32'(AWREADY), 32'd0);
        check("wready_after_aw", 32'(WREADY), 32'd1);

        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                @(posedge clk); #1;
                check("wready_in_gap", 32'(WREADY), 32'd1);
            end
            WVALID = 1'b1;
            WDATA  = beat_data[k];
            WSTRB  = beat_strb[k];
            WID    = (k == wid_bad) ? (id ^ 9'h001) : id;
            WLAST  = (k == len) ^ wlast_flip[k];
            check("wready_beat", 32'(WREADY), 32'd1);
            @(posedge clk); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;

        check("bvalid_after_last", 32'(BVALID), 32'd1);
        check("wready_after_last", 32'(WREADY), 32'd0);
        check("bid", 32'(BID), 32'(id));
        check("bresp", 32'(BRESP), 32'(exp_resp));

        for (int d = 0; d < bdelay; d++) begin
            @(posedge clk); #1;
            check("bvalid_held", 32'(BVALID), 32'd1);
            check("bid_held", 32'(BID), 32'(id));
            check("bresp_held", 32'(BRESP), 32'(exp_resp));
            check("awready_during_b", 32'(AWREADY), 32'd0);
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        check("bvalid_after_b_hs", 32'(BVALID), 32'd0);
        check("awready_right_after_b", 32'(AWREADY), 32'd0);
        @(posedge clk); #1;
        check("awready_back", 32'(AWREADY), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        AWID     = '0;
        AWADDR   = '0;
        AWLEN    = '0;
        AWSIZE   = '0;
        AWBURST  = '0;
        AWVALID  = 1'b0;
        WID      = '0;
        WDATA    = '0;
        WSTRB    = '0;
        WLAST    = 1'b0;
        WVALID   = 1'b0;
        BREADY   = 1'b0;
        dbg_addr = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_bid", 32'(BID), 32'd0);
        check("rst_bresp", 32'(BRESP), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("awready_after_rst", 32'(AWREADY), 32'd1);
        scan_mem("init");

        // ---- INCR, 4 beats of 16 bits ----
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = {8'hA0 + 8'(k), 8'hA0 + 8'(k)};
            beat_strb[k] = 2'b11;
        end
        do_burst(9'h055, 16'h0010, 3, 1, 1, -1, 16'h0, 0, 1'b0, 1'b0);
        peek(8,  "incr_w8",  16'hA0A0);
        peek(9,  "incr_w9",  16'hA1A1);
        peek(10, "incr_w10", 16'hA2A2);
        peek(11, "incr_w11", 16'hA3A3);

        // ---- WRAP from the middle of an 8-byte window ----
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = {8'hD0 + 8'(k), 8'hD0 + 8'(k)};
            beat_strb[k] = 2'b11;
        end
        do_burst(9'h012, 16'h0006, 3, 1, 2, -1, 16'h0, 0, 1'b0, 1'b0);
        peek(3, "wrap_w3", 16'hD0D0);
        peek(0, "wrap_w0", 16'hD1D1);
        peek(1, "wrap_w1", 16'hD2D2);
        peek(2, "wrap_w2", 16'hD3D3);

        // ---- FIXED with alternating strobes ----
        beat_data[0] = 16'h1111; beat_strb[0] = 2'b01;
        beat_data[1] = 16'h2222; beat_strb[1] = 2'b10;
        beat_data[2] = 16'h3333; beat_strb[2] = 2'b01;
        do_burst(9'h0F0, 16'h0004, 2, 1, 0, -1, 16'h0, 0, 1'b0, 1'b0);
        peek(2, "fixed_w2", 16'h2233);
        scan_mem("directed");

        // ---- error cases ----
        for (int k = 0; k < 16; k++) begin
            beat_data[k] = 16'hBEE0 + 16'(k);
            beat_strb[k] = 2'b11;
        end
        do_burst(9'h101, 16'h0040, 1, 2, 1, -1, 16'h0, 0, 1'b0, 1'b0);  // oversize beats
        do_burst(9'h102, 16'h0060, 1, 1, 1,  1, 16'h0, 0, 1'b0, 1'b0);  // WID mismatch on beat 1
        do_burst(9'h103, 16'h0080, 1, 1, 1, -1, 16'h1, 0, 1'b0, 1'b0);  // early WLAST
        do_burst(9'h104, 16'h0200, 0, 1, 1, -1, 16'h0, 0, 1'b0, 1'b0);  // word 256
        scan_mem("errors");

        // ---- B backpressure with W offered alongside AW ----
        do_burst(9'h1AB, 16'h00A0, 1, 1, 1, -1, 16'h0, 5, 1'b1, 1'b0);
        scan_mem("backpressure");

        // ---- reset in the middle of a burst ----
        AWID = 9'h077; AWADDR = 16'h0020; AWLEN = 4'd3; AWSIZE = 3'd1;
        AWBURST = 2'b01; AWVALID = 1'b1;
        for (int c = 0; c < 20 && !AWREADY; c++) begin
            @(posedge clk); #1;
        end
        check("midrst_awready", 32'(AWREADY), 32'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            WVALID = 1'b1; WID = 9'h077; WDATA = 16'h5A5A; WSTRB = 2'b11; WLAST = 1'b0;
            @(posedge clk); #1;
        end
        WVALID = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        check("midrst_awready_low", 32'(AWREADY), 32'd0);
        check("midrst_wready", 32'(WREADY), 32'd0);
        check("midrst_bvalid", 32'(BVALID), 32'd0);
        check("midrst_bid", 32'(BID), 32'd0);
        check("midrst_bresp", 32'(BRESP), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        check("midrst_awready_back", 32'(AWREADY), 32'd1);
        check("midrst_no_bvalid", 32'(BVALID), 32'd0);
        scan_mem("midrst");
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = 16'hC000 + 16'(k);
            beat_strb[k] = 2'b11;
        end
        do_burst(9'h033, 16'h0030, 3, 1, 1, -1, 16'h0, 0, 1'b0, 1'b0);
        scan_mem("after_rst");

        // ---- randomized bursts ----
        for (int t = 0; t < 40; t++) begin
            int          r, burst, size, len, wid_bad, bdelay;
            logic [15:0] addr, flip;
            r     = $urandom_range(0, 9);
            burst = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            size  = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
            if (burst == 2 && $urandom_range(0, 5) != 0) begin
                r   = $urandom_range(0, 3);
                len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 7 : 15;
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = 16'($urandom_range(0, 16'h021F));
            if (burst == 2 && $urandom_range(0, 5) != 0)
                addr = addr & ~(16'((1 << size) - 1));
            wid_bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            flip    = '0;
            if ($urandom_range(0, 7) == 0) flip[$urandom_range(0, len)] = 1'b1;
            bdelay  = $urandom_range(0, 3);
            for (int k = 0; k < 16; k++) begin
                beat_data[k] = 16'($urandom);
                beat_strb[k] = 2'($urandom_range(0, 3));
            end
            do_burst(9'($urandom), addr, len, size, burst, wid_bad, flip, bdelay,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            scan_mem($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
AXI3 write-path slave responder that sits directly downstream of the AXI interface's master side, on its AW/W/B channels. It accepts one write burst at a time and stores the data in an internal word-addressed memory. It returns a single B response per burst. A combinational debug read port lets scoreboards inspect the memory contents without using AXI.

Parameters:
A_WIDTH, 16, byte-address width of AWADDR
D_WIDTH, 16, data width in bits (multiple of 8, power of 2); STRB_W = D_WIDTH/8
MEM_DEPTH, 256, memory depth in D_WIDTH words (power of 2)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
AWID  input  9  write address ID
AWADDR  input  A_WIDTH  burst start byte address
AWLEN  input  4  beats minus one
AWSIZE  input  3  bytes per beat = 1<<AWSIZE
AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  input  1  address valid
AWREADY  output  1  address accepted
WID  input  9  write data ID
WDATA  input  D_WIDTH  write data
WSTRB  input  STRB_W  byte-lane enables
WLAST  input  1  master's last-beat marker
WVALID  input  1  data valid
WREADY  output  1  data accepted
BID  output  9  response ID (= captured AWID)
BRESP  output  2  00 OKAY, 10 SLVERR
BVALID  output  1  response valid
BREADY  input  1  response accepted
dbg_addr  input  log2(MEM_DEPTH)  debug word index
dbg_rdata  output  D_WIDTH  mem[dbg_addr], combinational

Behaviour:
- Reset: rst sampled high -> FSM=IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, error flag cleared, all memory words cleared to 0 (synchronous). rst has priority over everything, including mid-burst: the burst is abandoned, no B response. AWREADY rises the first cycle after rst is low.
- FSM states: IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - AWREADY=1.
  - On AWVALID&&AWREADY at edge N: capture ID, ADDR, LEN, SIZE, BURST; beat_cnt=0; go DATA.
  - AWREADY=0 from N+1.
- DATA:
  - WREADY=1 from N+1 (no wait states); AWREADY stays 0.
  - Each WVALID&&WREADY is one beat. Write WDATA byte lanes where WSTRB=1 into mem[addr >> log2(STRB_W)]; other lanes are untouched.
  - The block does not mask strobes by size.
- Address update after each beat:
  - FIXED: address unchanged.
  - INCR: addr += 1<<SIZE, aligned down to SIZE after the first beat.
  - WRAP: wrap boundary = (LEN+1)<<SIZE; addr = (addr & ~(bound-1)) | ((addr + (1<<SIZE)) & (bound-1)).
  - Address arithmetic is modulo 2^A_WIDTH.
- Error flag (sticky per burst, sets SLVERR):
  - SIZE > log2(STRB_W): no beats written.
  - BURST=11: no beats written.
  - WRAP with LEN not in {1,3,7,15}: no beats written.
  - Start address unaligned for WRAP: no beats written.
  - Word index >= MEM_DEPTH: that beat is dropped, others are still written.
  - WID != captured ID: beat still written.
  - WLAST=1 on a non-final beat, or WLAST=0 on the final beat: beat still written.
- Burst end: the burst ends on beat LEN+1 regardless of WLAST. At that edge, WREADY -> 0 and the FSM goes to RESP.
- RESP:
  - BVALID=1 the cycle after the last W handshake.
  - BID = captured ID; BRESP = 10 if error flag set, else 00.
  - BID/BRESP are held stable while BVALID && !BREADY.
  - On BVALID&&BREADY: BVALID=0 and go IDLE; AWREADY=1 on the following cycle.
- Throughput and latency: one outstanding burst. Minimum burst time = 1 (AW) + LEN+1 (W) + 1 (B) cycles, plus 1 idle cycle before the next AW.
- Simultaneous AWVALID and WVALID from the master: W is not accepted until the cycle after the AW handshake.
- dbg_rdata reflects a write on the edge after that write; there is no read-during-write bypass.

Test Plan:
- INCR, AWADDR=0x0010, LEN=3, SIZE=1, WDATA=0xA0A0..0xA3A3, WSTRB=11 -> words 8..11 = A0A0,A1A1,A2A2,A3A3; BRESP=00; BID=AWID=0x055; BVALID exactly 1 cycle after the 4th beat.
- WRAP, AWADDR=0x0006, LEN=3, SIZE=1, data D0..D3 -> words 3,0,1,2 receive D0,D1,D2,D3; BRESP=00.
- FIXED, AWADDR=0x0004, LEN=2, WSTRB=01,10,01, data 0x1111,0x2222,0x3333 -> word 2 = 0x2233; BRESP=00.
- Errors, each must give BRESP=10:
  - AWSIZE=2: memory unchanged.
  - WID mismatch on beat 1: data written.
  - WLAST early on beat 0 of LEN=1: both beats written.
  - AWADDR=0x0200 (word 256): nothing written.
- Backpressure: BREADY held low 5 cycles -> BVALID/BID/BRESP stable all 5 cycles; AWREADY=0 until 1 cycle after the B handshake.
- rst pulsed high after beat 1 of a LEN=3 burst -> next cycle all outputs 0, memory all 0, no BVALID; a new burst after reset completes with BRESP=00.
